// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns the word-addressed PC, issues pipelined
// requests to a variable-latency instruction memory and buffers words for decode.
module mips_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_HALT} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic [CW-1:0]     outstanding, outstanding_n;
    logic [CW-1:0]     fifo_count, fifo_count_n;
    logic [CW-1:0]     drop_cnt, drop_cnt_n;
    logic [PW-1:0]     fifo_rd, fifo_wr, tag_rd, tag_wr;
    logic [CW:0]       credit_sum;
    logic              accept, resp_live, drop, push, pop, req_valid_n;

    logic [ADDR_W-1:0] tag_mem   [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];

    assign accept    = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding belongs to a request issued before reset.
    assign resp_live = imem_resp_valid & (outstanding != '0);
    assign drop      = resp_live & (drop_cnt != '0);
    assign push      = resp_live & ~drop & ~redirect;
    assign pop       = instr_valid & instr_ready & ~redirect;

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        outstanding_n = outstanding + CW'(accept) - CW'(resp_live);
        fifo_count_n  = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
        // Everything still in flight after this cycle was fetched down the old path.
        drop_cnt_n    = redirect ? outstanding_n : drop_cnt - CW'(drop);
        fetch_pc_n    = redirect ? redirect_pc : fetch_pc + ADDR_W'(accept);

        if (state == S_WAIT)
            state_n = S_RUN;
        else if (halt && !redirect)
            state_n = S_HALT;
        else
            state_n = S_RUN;

        credit_sum  = {1'b0, outstanding_n} + {1'b0, fifo_count_n};
        req_valid_n = (state_n == S_RUN) && (credit_sum < DEPTH_SUM);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_WAIT;
            fetch_pc       <= RESET_PC;
            outstanding    <= '0;
            fifo_count     <= '0;
            drop_cnt       <= '0;
            fifo_rd        <= '0;
            fifo_wr        <= '0;
            tag_rd         <= '0;
            tag_wr         <= '0;
            imem_req_valid <= 1'b0;
        end else begin
            state          <= state_n;
            fetch_pc       <= fetch_pc_n;
            outstanding    <= outstanding_n;
            fifo_count     <= fifo_count_n;
            drop_cnt       <= drop_cnt_n;
            imem_req_valid <= req_valid_n;
            if (redirect) begin
                fifo_rd <= fifo_wr;
                tag_rd  <= tag_wr;
            end else begin
                if (push)   fifo_wr <= fifo_wr + PW'(1);
                if (pop)    fifo_rd <= fifo_rd + PW'(1);
                if (accept) tag_wr  <= tag_wr + PW'(1);
                if (push)   tag_rd  <= tag_rd + PW'(1);
            end
        end
    end

    // NOTE: storage arrays have no reset; pointers and counts decide which entries are live.
    always_ff @(posedge clock) begin
        if (accept && !redirect)
            tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
            fifo_data[fifo_wr] <= imem_resp_data;
        end
    end

    assign imem_req_addr = fetch_pc;
    assign instr_valid   = (fifo_count != '0);
    assign instr_pc      = instr_valid ? fifo_pc[fifo_rd]   : '0;
    assign instr_data    = instr_valid ? fifo_data[fifo_rd] : '0;
    assign busy          = (outstanding != '0);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus randomized
// traffic against a stream-level model of which fetched words decode must see.
module tb_mips_fetch_unit;
    localparam int                ADDR_W   = 8;
    localparam int                DATA_W   = 32;
    localparam int                DEPTH    = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'hFE;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid = 1'b0;
    logic [DATA_W-1:0] imem_resp_data = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;
    logic              busy;

    mips_fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } req_t;

    req_t              pend[$];      // accepted by memory, response not yet returned
    logic [ADDR_W-1:0] exp_q[$];     // fetched on the current path, not yet consumed by decode
    logic [ADDR_W-1:0] delivered[$];
    logic [ADDR_W-1:0] model_pc;
    int                cyc, since_reset, last_due, accepts;
    bit                last_halt, last_redir, last_req_stall, last_instr_stall;
    logic [ADDR_W-1:0] last_req_addr, last_instr_pc;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 8'hA5, ~a, a + 8'h3C, a};
    endfunction

    // Called just after a falling edge; asserts reset asynchronously between edges.
    task automatic do_reset();
        #1;
        reset_n         = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        halt            = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_busy", busy, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pend.delete();
        exp_q.delete();
        delivered.delete();
        model_pc         = RESET_PC;
        since_reset      = 0;
        last_due         = 0;
        accepts          = 0;
        last_halt        = 1'b0;
        last_redir       = 1'b0;
        last_req_stall   = 1'b0;
        last_instr_stall = 1'b0;
    endtask

    // One clock: check what the last edge left, drive inputs, update the model, advance.
    task automatic step(input bit rdy, input bit irdy, input bit redir,
                        input logic [ADDR_W-1:0] rpc, input bit hlt, input int lat);
        bit resp, acc, pop;
        int due;
        check("busy", busy, pend.size() != 0);
        if (exp_q.size() == 0)
            check("spurious_instr", instr_valid, 0);
        if (since_reset >= 2 && last_halt && !last_redir)
            check("req_while_halted", imem_req_valid, 0);
        if (last_req_stall) begin
            check("req_hold_valid", imem_req_valid, 1);
            check("req_hold_addr", imem_req_addr, last_req_addr);
        end
        if (last_instr_stall) begin
            check("instr_hold_valid", instr_valid, 1);
            check("instr_hold_pc", instr_pc, last_instr_pc);
        end

        resp            = (pend.size() != 0) && (pend[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(pend[0].addr) : DATA_W'($urandom);
        imem_req_ready  = rdy;
        instr_ready     = irdy;
        redirect        = redir;
        redirect_pc     = rpc;
        halt            = hlt;
        acc = imem_req_valid && rdy;
        pop = instr_valid && irdy;

        if (pop && !redir && exp_q.size() != 0) begin
            check("instr_pc", instr_pc, exp_q[0]);
            check("instr_data", instr_data, mem_word(exp_q[0]));
            delivered.push_back(instr_pc);
            void'(exp_q.pop_front());
        end
        if (resp)
            void'(pend.pop_front());
        if (acc) begin
            check("req_addr", imem_req_addr, model_pc);
            check("credit", pend.size() < DEPTH, 1);
            if (!redir)
                exp_q.push_back(model_pc);
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            pend.push_back('{imem_req_addr, due});
            model_pc = model_pc + 1'b1;
            accepts++;
        end
        if (redir) begin
            exp_q.delete();
            model_pc = rpc;
        end

        last_halt        = hlt;
        last_redir       = redir;
        last_req_stall   = imem_req_valid && !rdy && !redir && !hlt;
        last_req_addr    = imem_req_addr;
        last_instr_stall = instr_valid && !irdy && !redir;
        last_instr_pc    = instr_pc;

        @(posedge clock);
        @(negedge clock);
        cyc++;
        since_reset++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] want_pc;
        bit                halting;
        cyc = 0;
        @(negedge clock);

        // Streaming from reset with a 1-cycle memory; PC wraps 0xFF -> 0x00.
        do_reset();
        check("t1_wait_state", imem_req_valid, 0);
        step(1, 1, 0, '0, 0, 1);
        check("t1_first_req", imem_req_valid, 1);
        check("t1_first_addr", imem_req_addr, RESET_PC);
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, '0, 0, 1);
            if (since_reset < 3) begin
                check("t1_not_yet", instr_valid, 0);
            end else begin
                want_pc = RESET_PC + ADDR_W'(since_reset - 3);
                check("t1_valid", instr_valid, 1);
                check("t1_pc", instr_pc, want_pc);
            end
        end

        // Decode stalled: exactly DEPTH requests, then fetch stops until drained.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, '0, 0, 1);
            if (instr_valid) check("t2_head_hold", instr_pc, RESET_PC);
        end
        check("t2_accepts", accepts, DEPTH);
        check("t2_req_stopped", imem_req_valid, 0);
        for (int k = 0; k < 8; k++) step(1, 1, 0, '0, 0, 1);
        check("t2_delivered_n", delivered.size() >= 5, 1);
        if (delivered.size() >= 5) begin
            check("t2_d0", delivered[0], 8'hFE);
            check("t2_d1", delivered[1], 8'hFF);
            check("t2_d2", delivered[2], 8'h00);
            check("t2_d3", delivered[3], 8'h01);
            check("t2_d4", delivered[4], 8'h02);
        end

        // 3-cycle memory, redirect with two requests in flight.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 1, 0, '0, 0, 3);
        check("t3_busy", busy, 1);
        step(0, 1, 1, 8'h40, 0, 3);
        check("t3_drop_cnt", dut.drop_cnt, 2);
        for (int k = 0; k < 12; k++) step(1, 1, 0, '0, 0, 3);
        check("t3_delivered_n", delivered.size() >= 2, 1);
        if (delivered.size() >= 2) begin
            check("t3_d0", delivered[0], 8'h40);
            check("t3_d1", delivered[1], 8'h41);
        end

        // Redirect coinciding with a response and a request accept.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 1, 0, '0, 0, 2);
        check("t4_req_valid", imem_req_valid, 1);
        step(1, 1, 1, 8'h10, 0, 2);
        check("t4_drop_cnt", dut.drop_cnt, 2);
        for (int k = 0; k < 12; k++) step(1, 1, 0, '0, 0, 2);
        check("t4_delivered_n", delivered.size() >= 2, 1);
        if (delivered.size() >= 2) begin
            check("t4_d0", delivered[0], 8'h10);
            check("t4_d1", delivered[1], 8'h11);
        end

        // Halt mid-stream: in-flight words drain, busy falls, fetch resumes sequentially.
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 1, 0, '0, 0, 2);
        for (int k = 0; k < 10; k++) step(1, 1, 0, '0, 1, 2);
        check("t5_busy", busy, 0);
        check("t5_instr_valid", instr_valid, 0);
        check("t5_req_valid", imem_req_valid, 0);
        step(1, 1, 0, '0, 0, 2);
        check("t5_resume_valid", imem_req_valid, 1);
        check("t5_resume_addr", imem_req_addr, model_pc);
        for (int k = 0; k < 8; k++) step(1, 1, 0, '0, 0, 2);

        // Randomized traffic: backpressure, latency, redirects, halts, rare resets.
        halting = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if (halting) halting = ($urandom_range(0, 3) != 0);
            else         halting = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, ADDR_W'($urandom), halting,
                 $urandom_range(1, 4));
        end

        // Reset pulsed mid-stream clears everything at once and restarts at RESET_PC.
        do_reset();
        for (int k = 0; k < 7; k++) step(1, 0, 0, '0, 0, 3);
        check("t7_pre_valid", instr_valid, 1);
        check("t7_pre_busy", busy, 1);
        do_reset();
        for (int k = 0; k < 8; k++) step(1, 1, 0, '0, 0, 1);
        check("t7_delivered_n", delivered.size() >= 1, 1);
        if (delivered.size() >= 1) check("t7_d0", delivered[0], RESET_PC);

        // Drain with a bounded budget.
        for (int k = 0; k < 100; k++) begin
            if (pend.size() == 0 && !instr_valid && !imem_req_valid) break;
            step(1, 1, 0, '0, 1, 1);
        end
        check("drain_busy", busy, 0);
        check("drain_instr_valid", instr_valid, 0);
        check("drain_undelivered", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
